// File: rtl/clock_strobe_gen.sv
// clock_strobe_gen: turns the NCO dot_clock square wave into clk-domain strobes,
// tracks the pixel index / CPU phase, and measures dot_clock frequency per window.
module clock_strobe_gen #(
    parameter int unsigned WIN_BITS = 16,
    parameter int unsigned EXP_CNT  = 3640,
    parameter int unsigned TOL      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dot_clock,
    output logic        dot_stb,
    output logic [2:0]  pix,
    output logic        phi0,
    output logic        phi0_rise,
    output logic        phi0_fall,
    output logic [15:0] freq_cnt,
    output logic        meas_stb,
    output logic        freq_ok
);

    localparam int unsigned CNT_W = 16;
    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_CNT);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

    logic                    dot_q;
    logic [WIN_BITS-1:0]     win_cnt;
    logic [CNT_W-1:0]        edge_cnt;

    logic                    rise_c;
    logic [2:0]              pix_next_c;
    logic                    win_end_c;
    logic [CNT_W:0]          edge_sum_c;
    logic [CNT_W-1:0]        edge_sat_c;
    logic signed [CNT_W:0]   diff_c;
    logic                    ok_c;

    // Rising edge of dot_clock, pixel increment and window-closing count.
    always_comb begin
        rise_c     = dot_clock & ~dot_q;
        pix_next_c = pix + 3'd1;
        win_end_c  = &win_cnt;
        edge_sum_c = {1'b0, edge_cnt} + (CNT_W+1)'(dot_stb);
        edge_sat_c = edge_sum_c[CNT_W] ? {CNT_W{1'b1}} : edge_sum_c[CNT_W-1:0];
        diff_c     = $signed({1'b0, edge_sat_c}) - EXP_S;
        ok_c       = (diff_c >= -TOL_S) && (diff_c <= TOL_S);
    end

    // dot_clock history; also loaded in reset so a high level at release is not an edge.
    always_ff @(posedge clk) begin
        dot_q <= dot_clock;
    end

    // Dot strobe, pixel counter and phi0 edge strobes, all updated on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            dot_stb   <= 1'b0;
            pix       <= 3'd0;
            phi0      <= 1'b0;
            phi0_rise <= 1'b0;
            phi0_fall <= 1'b0;
        end else begin
            dot_stb   <= rise_c;
            phi0_rise <= rise_c && (pix == 3'd3);
            phi0_fall <= rise_c && (pix == 3'd7);
            if (rise_c) begin
                pix  <= pix_next_c;
                phi0 <= pix_next_c[2];
            end
        end
    end

    // Windowed edge counter; the strobe in the last window cycle still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            freq_cnt <= '0;
            meas_stb <= 1'b0;
            freq_ok  <= 1'b0;
        end else begin
            win_cnt <= win_cnt + WIN_BITS'(1);
            if (win_end_c) begin
                freq_cnt <= edge_sat_c;
                freq_ok  <= ok_c;
                edge_cnt <= '0;
                meas_stb <= 1'b1;
            end else begin
                edge_cnt <= edge_sat_c;
                meas_stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_strobe_gen.sv
// Bench for clock_strobe_gen: per-cycle scoreboard against a behavioural model,
// a hand-derived vector table for edge/pixel behaviour, and window-level scenarios.
module tb_clock_strobe_gen;

    localparam int WB  = 10;
    localparam int WIN = 1 << WB;
    localparam int EXP = 57;    // 3640 * 1024 / 65536 = 56.875
    localparam int TOL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dot_clock = 1'b0;
    logic        dot_stb;
    logic [2:0]  pix;
    logic        phi0;
    logic        phi0_rise;
    logic        phi0_fall;
    logic [15:0] freq_cnt;
    logic        meas_stb;
    logic        freq_ok;

    clock_strobe_gen #(.WIN_BITS(WB), .EXP_CNT(EXP), .TOL(TOL)) dut (
        .clk       (clk),
        .reset     (reset),
        .dot_clock (dot_clock),
        .dot_stb   (dot_stb),
        .pix       (pix),
        .phi0      (phi0),
        .phi0_rise (phi0_rise),
        .phi0_fall (phi0_fall),
        .freq_cnt  (freq_cnt),
        .meas_stb  (meas_stb),
        .freq_ok   (freq_ok)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stb;
        logic [2:0]  pix;
        logic        phi0;
        logic        rise;
        logic        fall;
        logic        meas;
        logic [15:0] freq;
        logic        ok;
    } obs_t;

    typedef struct {
        logic       r;
        logic       d;
        logic       stb;
        logic [2:0] pix;
        logic       phi0;
        logic       rise;
        logic       fall;
    } vec_t;

    obs_t        sb_q[$];
    vec_t        tbl[24];
    int          checks = 0;
    int          failures = 0;
    int          rel_cyc = 0;
    int          cyc_no = 0;
    logic [15:0] acc = '0;
    logic        tog = 1'b0;

    // behavioural model state
    logic m_dq = 1'b0;
    logic m_stb = 1'b0;
    logic m_ok = 1'b0;
    int   m_pix = 0;
    int   m_win = 0;
    int   m_edges = 0;
    int   m_freq = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o = {dot_stb, pix, phi0, phi0_rise, phi0_fall, meas_stb, freq_cnt, freq_ok};
        return o;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", nm, cyc_no, act, exp);
        end
    endtask

    // Drive one cycle, push the model's expected outputs, then compare after the edge.
    task automatic step(input logic r, input logic d);
        obs_t e;
        logic ns;
        int   s;
        reset     = r;
        dot_clock = d;
        e = '0;
        if (r) begin
            m_dq = d; m_pix = 0; m_win = 0; m_edges = 0; m_freq = 0;
            m_stb = 1'b0; m_ok = 1'b0; rel_cyc = 0;
        end else begin
            ns = d && !m_dq;
            if (m_win == WIN - 1) begin
                s      = m_edges + int'(m_stb);
                m_freq = (s > 65535) ? 65535 : s;
                m_ok   = (m_freq >= EXP - TOL) && (m_freq <= EXP + TOL);
                m_edges = 0;
                e.meas = 1'b1;
            end else begin
                m_edges = m_edges + int'(m_stb);
                if (m_edges > 65535) m_edges = 65535;
            end
            m_win = (m_win + 1) % WIN;
            if (ns) begin
                e.rise = (m_pix == 3);
                e.fall = (m_pix == 7);
                m_pix  = (m_pix + 1) % 8;
            end
            m_stb = ns;
            m_dq  = d;
            rel_cyc++;
            e.stb  = ns;
            e.pix  = 3'(m_pix);
            e.phi0 = (m_pix >= 4);
            e.freq = 16'(m_freq);
            e.ok   = m_ok;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
        e = sb_q.pop_front();
        check("cycle", 32'(dut_obs()), 32'(e));
    endtask

    // Run until the DUT reports a window (bounded); mode picks the dot_clock pattern.
    task automatic run_window(input int mode, output int cyc_at_meas);
        logic d;
        bit   got;
        got = 1'b0;
        cyc_at_meas = -1;
        for (int i = 0; i < WIN + 16 && !got; i++) begin
            case (mode)
                0:       d = 1'b0;
                1:       begin tog = ~tog; d = tog; end
                2:       begin acc = acc + 16'd3640; d = acc[15]; end
                default: d = (rel_cyc + 1 >= WIN - 1);
            endcase
            step(1'b0, d);
            if (meas_stb) begin
                got = 1'b1;
                cyc_at_meas = rel_cyc;
            end
        end
        check("meas_stb_seen", 32'(got), 32'd1);
    endtask

    initial begin
        int c;
        // {reset, dot_clock, dot_stb, pix, phi0, phi0_rise, phi0_fall}
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 1, 2, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 2, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 2, 0, 0, 0};
        tbl[10] = '{0, 1, 1, 3, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 3, 0, 0, 0};
        tbl[12] = '{0, 1, 1, 4, 1, 1, 0};
        tbl[13] = '{0, 1, 0, 4, 1, 0, 0};
        tbl[14] = '{0, 0, 0, 4, 1, 0, 0};
        tbl[15] = '{0, 1, 1, 5, 1, 0, 0};
        tbl[16] = '{0, 0, 0, 5, 1, 0, 0};
        tbl[17] = '{0, 1, 1, 6, 1, 0, 0};
        tbl[18] = '{0, 0, 0, 6, 1, 0, 0};
        tbl[19] = '{0, 1, 1, 7, 1, 0, 0};
        tbl[20] = '{0, 0, 0, 7, 1, 0, 0};
        tbl[21] = '{0, 1, 1, 0, 0, 0, 1};
        tbl[22] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[23] = '{1, 1, 0, 0, 0, 0, 0};

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].r, tbl[i].d);
            check($sformatf("vec%0d", i),
                  32'({dot_stb, pix, phi0, phi0_rise, phi0_fall}),
                  32'({tbl[i].stb, tbl[i].pix, tbl[i].phi0, tbl[i].rise, tbl[i].fall}));
        end

        // dot_clock high through reset release: nothing may move
        step(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1);
            check("hold_high_zero", 32'(dut_obs()), 32'd0);
        end

        // nominal NCO
        step(1'b1, 1'b0);
        acc = '0;
        run_window(2, c);
        check("nom_first_meas_cycle", 32'(c), 32'(WIN));
        check("nom_cnt_in_range", 32'(freq_cnt >= 16'd56 && freq_cnt <= 16'd57), 32'd1);
        check("nom_ok", 32'(freq_ok), 32'd1);

        // one-cycle reset part-way through a window
        for (int i = 0; i < 300; i++) begin
            acc = acc + 16'd3640;
            step(1'b0, acc[15]);
        end
        step(1'b1, acc[15]);
        check("mid_reset_pix", 32'(pix), 32'd0);
        check("mid_reset_freq", 32'(freq_cnt), 32'd0);
        run_window(2, c);
        check("mid_reset_meas_cycle", 32'(c), 32'(WIN));

        // dot_clock stuck low
        step(1'b1, 1'b0);
        for (int w = 0; w < 2; w++) begin
            run_window(0, c);
            check("stuck_cycle", 32'(c), 32'((w + 1) * WIN));
            check("stuck_freq", 32'(freq_cnt), 32'd0);
            check("stuck_ok", 32'(freq_ok), 32'd0);
            check("stuck_pix", 32'(pix), 32'd0);
        end

        // dot_clock toggling every cycle
        step(1'b1, 1'b0);
        tog = 1'b0;
        run_window(1, c);
        check("toggle_freq", 32'(freq_cnt), 32'(WIN / 2));
        check("toggle_ok", 32'(freq_ok), 32'd0);

        // single edge whose strobe lands in the last window cycle
        step(1'b1, 1'b0);
        run_window(3, c);
        check("last_cycle_freq", 32'(freq_cnt), 32'd1);
        run_window(3, c);
        check("next_window_freq", 32'(freq_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
